instruction_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory read port: owns the PC, drives the word

---
 rtl/instruction_fetch_unit_pkg.sv | 15 +
 rtl/pc_register.sv | 31 +++
 rtl/instruction_fetch_unit.sv | 94 +++++++++
 tb/tb_instruction_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and the IF/ID pipeline register layout for the fetch stage.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] NopInstr = 32'h0000_0000;
    localparam logic [31:0] PcIncr   = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t Bubble = '{instr: NopInstr, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/pc_register.sv
// Program counter register with load enable and synchronous reset to RESET_PC.
module pc_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load_en_i,
    input  logic [31:0] next_pc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_en_i) begin
            pc_d = next_pc_i;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory and fills
// the IF/ID register, handling redirect, stall, flush and out-of-range fetches.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 2048
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] Target,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    output logic [31:0] IFID_Instr,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        RangeFault,
    output logic        AlignFault
);

    localparam logic [29:0] ImemWordsW = 30'(IMEM_WORDS);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        pc_load;
    logic        in_range;

    ifid_t ifid_d, ifid_q;
    logic  range_d, range_q;
    logic  align_d, align_q;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .Clk       (Clk),
        .Reset     (Reset),
        .load_en_i (pc_load),
        .next_pc_i (pc_next),
        .pc_o      (pc)
    );

    assign pc_plus4 = pc + PcIncr;
    assign in_range = pc[31:2] < ImemWordsW;

    always_comb begin
        ifid_d  = ifid_q;
        range_d = range_q;
        align_d = 1'b0;
        pc_load = 1'b1;
        pc_next = pc_plus4;
        if (Redirect) begin
            // Redirect wins over Stall: the wrong-path fetch is squashed.
            pc_next = {Target[31:2], 2'b00};
            ifid_d  = Bubble;
            align_d = |Target[1:0];
        end else if (Stall) begin
            pc_load = 1'b0;
            if (Flush) begin
                ifid_d = Bubble;
            end
        end else if (!in_range) begin
            ifid_d  = Bubble;
            range_d = 1'b1;
        end else if (Flush) begin
            ifid_d = Bubble;
        end else begin
            ifid_d = '{instr: Instruction, pc_plus4: pc_plus4, valid: 1'b1};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ifid_q  <= Bubble;
            range_q <= 1'b0;
            align_q <= 1'b0;
        end else begin
            ifid_q  <= ifid_d;
            range_q <= range_d;
            align_q <= align_d;
        end
    end

    assign Address      = pc;
    assign IFID_Instr   = ifid_q.instr;
    assign IFID_PCPlus4 = ifid_q.pc_plus4;
    assign IFID_Valid   = ifid_q.valid;
    assign RangeFault   = range_q;
    assign AlignFault   = align_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed scenarios plus randomized control against a
// behavioural model of the fetch stage.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, Redirect;
    logic [31:0] Target;
    logic [31:0] Address, Instruction, IFID_Instr, IFID_PCPlus4;
    logic        IFID_Valid, RangeFault, AlignFault;

    logic        Reset_r;
    logic [31:0] Address_r, Instruction_r, IFID_Instr_r, IFID_PCPlus4_r;
    logic        IFID_Valid_r, RangeFault_r, AlignFault_r;

    logic [31:0] mem [0:2047];

    int checks   = 0;
    int failures = 0;

    // Model of the default-parameter instance.
    logic [31:0] m_pc, m_instr, m_pcp4;
    logic        m_valid, m_range, m_align;

    always #5 Clk = ~Clk;

    assign Instruction   = mem[Address[12:2]];
    assign Instruction_r = mem[Address_r[12:2]];

    instruction_fetch_unit dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .Flush        (Flush),
        .Redirect     (Redirect),
        .Target       (Target),
        .Address      (Address),
        .Instruction  (Instruction),
        .IFID_Instr   (IFID_Instr),
        .IFID_PCPlus4 (IFID_PCPlus4),
        .IFID_Valid   (IFID_Valid),
        .RangeFault   (RangeFault),
        .AlignFault   (AlignFault)
    );

    instruction_fetch_unit #(
        .RESET_PC   (32'd60),
        .IMEM_WORDS (16)
    ) dut_r (
        .Clk          (Clk),
        .Reset        (Reset_r),
        .Stall        (1'b0),
        .Flush        (1'b0),
        .Redirect     (1'b0),
        .Target       (32'h0),
        .Address      (Address_r),
        .Instruction  (Instruction_r),
        .IFID_Instr   (IFID_Instr_r),
        .IFID_PCPlus4 (IFID_PCPlus4_r),
        .IFID_Valid   (IFID_Valid_r),
        .RangeFault   (RangeFault_r),
        .AlignFault   (AlignFault_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bubble_model();
        m_instr = 32'h0;
        m_pcp4  = 32'h0;
        m_valid = 1'b0;
    endtask

    // Applies one clock edge worth of the fetch rules to the model.
    task automatic model_edge();
        logic fetch_ok;
        if (Reset) begin
            m_pc    = 32'h0;
            m_range = 1'b0;
            m_align = 1'b0;
            bubble_model();
        end else if (Redirect) begin
            m_align = (Target % 4) != 0;
            m_pc    = Target - (Target % 4);
            bubble_model();
        end else begin
            m_align  = 1'b0;
            fetch_ok = (m_pc / 4) < 2048;
            if (Stall) begin
                if (Flush) bubble_model();
            end else begin
                if (!fetch_ok) begin
                    m_range = 1'b1;
                    bubble_model();
                end else if (Flush) begin
                    bubble_model();
                end else begin
                    m_instr = mem[m_pc / 4];
                    m_pcp4  = m_pc + 4;
                    m_valid = 1'b1;
                end
                m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_addr"},  Address,      m_pc);
        check({tag, "_instr"}, IFID_Instr,   m_instr);
        check({tag, "_pcp4"},  IFID_PCPlus4, m_pcp4);
        check({tag, "_valid"}, 32'(IFID_Valid), 32'(m_valid));
        check({tag, "_range"}, 32'(RangeFault), 32'(m_range));
        check({tag, "_align"}, 32'(AlignFault), 32'(m_align));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'(i * 3);
        Reset = 1'b1; Reset_r = 1'b1;
        Stall = 1'b0; Flush = 1'b0; Redirect = 1'b0; Target = 32'h0;

        // Reset held two cycles, then free run.
        tick(); tick();
        Reset = 1'b0;
        check("rst_addr",  Address,      32'h0);
        check("rst_valid", 32'(IFID_Valid), 32'h0);
        check("rst_instr", IFID_Instr,   32'h0);
        check("rst_range", 32'(RangeFault), 32'h0);
        check("rst_align", 32'(AlignFault), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("run_instr", IFID_Instr,   32'(i * 3));
            check("run_pcp4",  IFID_PCPlus4, 32'(4 * (i + 1)));
            check("run_valid", 32'(IFID_Valid), 32'h1);
            check("run_addr",  Address,      32'(4 * (i + 1)));
        end

        // Stall at PC=8.
        Reset = 1'b1; tick(); Reset = 1'b0;
        tick(); tick();
        check("pre_stall_addr", Address, 32'h8);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr",  Address,      32'h8);
            check("stall_instr", IFID_Instr,   32'h3);
            check("stall_pcp4",  IFID_PCPlus4, 32'h8);
        end
        Stall = 1'b0;
        tick();
        check("resume_addr",  Address,    32'hC);
        check("resume_instr", IFID_Instr, 32'h6);

        // Redirect beats Stall; misaligned target pulses AlignFault.
        Stall = 1'b1; Redirect = 1'b1; Target = 32'h40;
        tick();
        check("redir_addr",  Address,          32'h40);
        check("redir_valid", 32'(IFID_Valid),  32'h0);
        check("redir_align", 32'(AlignFault),  32'h0);
        Target = 32'h42;
        tick();
        check("mis_addr",  Address,         32'h40);
        check("mis_align", 32'(AlignFault), 32'h1);
        Redirect = 1'b0; Stall = 1'b0;
        tick();
        check("mis_align_clr", 32'(AlignFault), 32'h0);
        check("post_redir_instr", IFID_Instr, 32'd48);
        check("post_redir_addr",  Address,    32'h44);

        // Flush: with Stall PC holds, without it PC advances; both bubble.
        Flush = 1'b1; Stall = 1'b1;
        tick();
        check("flush_stall_addr",  Address,         32'h44);
        check("flush_stall_valid", 32'(IFID_Valid), 32'h0);
        Stall = 1'b0;
        tick();
        check("flush_addr",  Address,         32'h48);
        check("flush_valid", 32'(IFID_Valid), 32'h0);
        Flush = 1'b0;
        tick();
        check("post_flush_instr", IFID_Instr,   32'd54);
        check("post_flush_pcp4",  IFID_PCPlus4, 32'h4C);

        // Reset wins over a simultaneous redirect.
        Redirect = 1'b1; Target = 32'h80; Reset = 1'b1;
        tick();
        Redirect = 1'b0; Reset = 1'b0;
        check_all("rst_redir");
        check("rst_redir_addr", Address, 32'h0);

        // Randomized control against the model.
        for (int i = 0; i < 400; i++) begin
            Reset    = $urandom_range(0, 99) < 2;
            Stall    = $urandom_range(0, 99) < 25;
            Flush    = $urandom_range(0, 99) < 15;
            Redirect = $urandom_range(0, 99) < 15;
            Target   = 32'($urandom_range(0, 7600));
            tick();
            check_all("rand");
        end
        Reset = 1'b0; Stall = 1'b0; Flush = 1'b0; Redirect = 1'b0;

        // Last implemented word, then out-of-range fetches on the small instance.
        tick();
        Reset_r = 1'b0;
        check("rng_rst_addr",  Address_r,          32'd60);
        check("rng_rst_valid", 32'(IFID_Valid_r),  32'h0);
        tick();
        check("rng_last_instr", IFID_Instr_r,       32'd45);
        check("rng_last_pcp4",  IFID_PCPlus4_r,     32'd64);
        check("rng_last_valid", 32'(IFID_Valid_r),  32'h1);
        check("rng_last_fault", 32'(RangeFault_r),  32'h0);
        tick();
        check("rng_oor_valid", 32'(IFID_Valid_r),  32'h0);
        check("rng_oor_instr", IFID_Instr_r,       32'h0);
        check("rng_oor_fault", 32'(RangeFault_r),  32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rng_sticky", 32'(RangeFault_r), 32'h1);
        end
        Reset_r = 1'b1;
        tick();
        check("rng_clr", 32'(RangeFault_r), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
